// File: rtl/stream_pkg.sv
// Shared constants and helpers for the registered stream multiplexer.
package stream_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Never narrower than one bit, so index ports stay legal for any N.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/skid_buffer_2.sv
// Two-entry output stage: a main register feeding the consumer plus one skid
// entry that absorbs the word accepted in the cycle the consumer stalls.
module skid_buffer_2 #(
    parameter int DW = 34
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          main_valid_q;
    logic          skid_valid_q;
    logic          push;
    logic          pop;

    assign in_ready  = ~skid_valid_q;
    assign push      = in_valid & in_ready;
    assign pop       = main_valid_q & out_ready;
    assign out_data  = main_q;
    assign out_valid = main_valid_q;

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; the data registers are reset as well because the
    // output data must read zero after reset, not stale contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (pop || !main_valid_q) begin
            // Main is free this cycle: the older skid word always goes first.
            if (skid_valid_q) begin
                main_q       <= skid_q;
                main_valid_q <= 1'b1;
                skid_valid_q <= push;
                if (push) begin
                    skid_q <= in_data;
                end
            end else if (push) begin
                main_q       <= in_data;
                main_valid_q <= 1'b1;
            end else begin
                main_valid_q <= 1'b0;
            end
        end else if (push) begin
            skid_q       <= in_data;
            skid_valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/stream_mux_reg.sv
// Registered N-to-1 stream multiplexer with external-select or round-robin
// arbitration feeding a two-entry skid-buffered output stage.
module stream_mux_reg
    import stream_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    parameter  int MODE  = MODE_SEL,
    localparam int SEL_W = clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SEL_W-1:0]     sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sel_err
);

    localparam int DW = WIDTH + SEL_W;

    logic [N-1:0]     grant_sel;
    logic [N-1:0]     grant_rr;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [SEL_W-1:0] ptr;
    logic             found;
    logic             acc;
    logic             buf_ready;
    logic             sel_bad;
    logic [DW-1:0]    buf_out;

    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_sel = '0;
        for (int i = 0; i < N; i++) begin
            grant_sel[i] = (sel == SEL_W'(i));
        end
    end

    // ptr + k spans 1 .. 2N-1, so matching i or i+N gives the modulo-N wrap
    // without a divider, also for non-power-of-two N.
    always_comb begin
        grant_rr = '0;
        found    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && in_valid[i] &&
                    ((int'(ptr) + k == i) || (int'(ptr) + k == i + N))) begin
                    grant_rr[i] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
    end

    assign grant = (MODE == MODE_RR) ? grant_rr : grant_sel;

    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx  = SEL_W'(i);
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = grant & {N{buf_ready & ~rst}};
    assign acc      = |(in_valid & in_ready);
    assign sel_bad  = (MODE == MODE_SEL) && (32'(sel) >= N) && (|in_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= SEL_W'(N - 1);
            sel_err <= 1'b0;
        end else begin
            sel_err <= sel_bad;
            if (acc) begin
                ptr <= grant_idx;
            end
        end
    end

    skid_buffer_2 #(
        .DW(DW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({grant_idx, grant_data}),
        .in_valid  (acc),
        .in_ready  (buf_ready),
        .out_data  (buf_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_data = buf_out[WIDTH-1:0];
    assign out_idx  = buf_out[DW-1:WIDTH];

endmodule

// File: tb/tb_stream_mux_reg.sv
// Scoreboard bench for stream_mux_reg: select-mode N=4 and N=3 instances and
// a round-robin N=4 instance share clock and reset.
module tb_stream_mux_reg;
    import stream_pkg::*;

    typedef logic [33:0] exp_t;

    logic clk;
    logic rst;

    logic [127:0] s4_in_data;
    logic [3:0]   s4_in_valid, s4_in_ready;
    logic [1:0]   s4_sel, s4_out_idx;
    logic [31:0]  s4_out_data;
    logic         s4_out_valid, s4_out_ready, s4_sel_err;

    logic [95:0]  s3_in_data;
    logic [2:0]   s3_in_valid, s3_in_ready;
    logic [1:0]   s3_sel, s3_out_idx;
    logic [31:0]  s3_out_data;
    logic         s3_out_valid, s3_out_ready, s3_sel_err;

    logic [127:0] rr_in_data;
    logic [3:0]   rr_in_valid, rr_in_ready;
    logic [1:0]   rr_sel, rr_out_idx;
    logic [31:0]  rr_out_data;
    logic         rr_out_valid, rr_out_ready, rr_sel_err;

    exp_t q_s4[$];
    exp_t q_s3[$];
    exp_t q_rr[$];
    exp_t exp_s4, exp_s3, exp_rr;

    logic [1:0] rr_ptr_m;
    int checks = 0;
    int errors = 0;

    stream_mux_reg #(.WIDTH(32), .N(4), .MODE(MODE_SEL)) u_s4 (
        .clk(clk), .rst(rst), .in_data(s4_in_data), .in_valid(s4_in_valid),
        .in_ready(s4_in_ready), .sel(s4_sel), .out_data(s4_out_data),
        .out_idx(s4_out_idx), .out_valid(s4_out_valid), .out_ready(s4_out_ready),
        .sel_err(s4_sel_err)
    );

    stream_mux_reg #(.WIDTH(32), .N(3), .MODE(MODE_SEL)) u_s3 (
        .clk(clk), .rst(rst), .in_data(s3_in_data), .in_valid(s3_in_valid),
        .in_ready(s3_in_ready), .sel(s3_sel), .out_data(s3_out_data),
        .out_idx(s3_out_idx), .out_valid(s3_out_valid), .out_ready(s3_out_ready),
        .sel_err(s3_sel_err)
    );

    stream_mux_reg #(.WIDTH(32), .N(4), .MODE(MODE_RR)) u_rr (
        .clk(clk), .rst(rst), .in_data(rr_in_data), .in_valid(rr_in_valid),
        .in_ready(rr_in_ready), .sel(rr_sel), .out_data(rr_out_data),
        .out_idx(rr_out_idx), .out_valid(rr_out_valid), .out_ready(rr_out_ready),
        .sel_err(rr_sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before the summary line");
        $fatal(1, "watchdog");
    end

    // Output monitors: every completed handshake must match the queue head.
    always @(negedge clk) begin
        if (!rst && s4_out_valid === 1'b1 && s4_out_ready) begin
            checks++;
            if (q_s4.size() == 0) begin
                errors++;
                $display("FAIL s4_unexpected got idx=%0d data=%h, none expected", s4_out_idx, s4_out_data);
            end else begin
                exp_s4 = q_s4.pop_front();
                if ({s4_out_idx, s4_out_data} !== exp_s4) begin
                    errors++;
                    $display("FAIL s4_out got idx=%0d data=%h, expected idx=%0d data=%h",
                             s4_out_idx, s4_out_data, exp_s4[33:32], exp_s4[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && s3_out_valid === 1'b1 && s3_out_ready) begin
            checks++;
            if (q_s3.size() == 0) begin
                errors++;
                $display("FAIL s3_unexpected got idx=%0d data=%h, none expected", s3_out_idx, s3_out_data);
            end else begin
                exp_s3 = q_s3.pop_front();
                if ({s3_out_idx, s3_out_data} !== exp_s3) begin
                    errors++;
                    $display("FAIL s3_out got idx=%0d data=%h, expected idx=%0d data=%h",
                             s3_out_idx, s3_out_data, exp_s3[33:32], exp_s3[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rr_out_valid === 1'b1 && rr_out_ready) begin
            checks++;
            if (q_rr.size() == 0) begin
                errors++;
                $display("FAIL rr_unexpected got idx=%0d data=%h, none expected", rr_out_idx, rr_out_data);
            end else begin
                exp_rr = q_rr.pop_front();
                if ({rr_out_idx, rr_out_data} !== exp_rr) begin
                    errors++;
                    $display("FAIL rr_out got idx=%0d data=%h, expected idx=%0d data=%h",
                             rr_out_idx, rr_out_data, exp_rr[33:32], exp_rr[31:0]);
                end
            end
        end
    end

    // Reference round-robin pick: {found, index}, searching upward from ptr+1.
    function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (int'(ptr) + k) % 4;
            if (v[c]) return {1'b1, 2'(c)};
        end
        return 3'b000;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        s4_in_valid = 4'hF; s4_sel = 2'd1; s4_out_ready = 1'b1;
        s3_in_valid = 3'h7; s3_sel = 2'd0; s3_out_ready = 1'b1;
        rr_in_valid = 4'hF; rr_sel = 2'd0; rr_out_ready = 1'b1;
        s4_in_data = '1; s3_in_data = '1; rr_in_data = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s4_out_valid, s4_sel_err, s4_out_idx, s4_out_data, s4_in_ready} !== '0) begin
            errors++;
            $display("FAIL s4_reset got valid=%b err=%b idx=%0d data=%h rdy=%b, expected all zero",
                     s4_out_valid, s4_sel_err, s4_out_idx, s4_out_data, s4_in_ready);
        end
        checks++;
        if ({s3_out_valid, s3_sel_err, s3_out_idx, s3_out_data, s3_in_ready} !== '0) begin
            errors++;
            $display("FAIL s3_reset got valid=%b err=%b idx=%0d data=%h rdy=%b, expected all zero",
                     s3_out_valid, s3_sel_err, s3_out_idx, s3_out_data, s3_in_ready);
        end
        checks++;
        if ({rr_out_valid, rr_sel_err, rr_out_idx, rr_out_data, rr_in_ready} !== '0) begin
            errors++;
            $display("FAIL rr_reset got valid=%b err=%b idx=%0d data=%h rdy=%b, expected all zero",
                     rr_out_valid, rr_sel_err, rr_out_idx, rr_out_data, rr_in_ready);
        end
        @(posedge clk); #1;
        s4_in_valid = '0; s3_in_valid = '0; rr_in_valid = '0;
        rst = 1'b0;
        rr_ptr_m = 2'd3;
    endtask

    task automatic test_sel_basic();
        s4_out_ready = 1'b1;
        @(posedge clk); #1;
        s4_in_data = '0;
        s4_in_data[2*32 +: 32] = 32'hDEADBEEF;
        s4_sel = 2'd2;
        s4_in_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (s4_in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL sel_single_ready got %b expected 0100", s4_in_ready);
        end
        q_s4.push_back({2'd2, 32'hDEADBEEF});
        @(posedge clk); #1;
        s4_in_valid = '0;
        @(negedge clk);
        checks++;
        if (s4_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL sel_single_latency got out_valid=%b expected 1", s4_out_valid);
        end
        // Back-to-back: a new select every cycle with all channels valid.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) s4_in_data[i*32 +: 32] = 32'hA5000000 + 32'(k*256 + i);
            s4_sel = 2'(k);
            s4_in_valid = 4'hF;
            @(negedge clk);
            checks++;
            if (s4_in_ready !== (4'b0001 << k) || s4_sel_err !== 1'b0) begin
                errors++;
                $display("FAIL sel_b2b_ready sel=%0d got rdy=%b err=%b expected rdy=%b err=0",
                         k, s4_in_ready, s4_sel_err, 4'b0001 << k);
            end
            q_s4.push_back({2'(k), 32'hA5000000 + 32'(k*256 + k)});
        end
        @(posedge clk); #1;
        s4_in_valid = '0;
        for (int i = 0; i < 20 && q_s4.size() != 0; i++) @(negedge clk);
        checks++;
        if (q_s4.size() != 0) begin
            errors++;
            $display("FAIL sel_drain got %0d pending words expected 0", q_s4.size());
        end
    endtask

    task automatic test_sel_err();
        s3_out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) s3_in_data[i*32 +: 32] = 32'hC0DE0000 + 32'(i);
        s3_sel = 2'd3;
        s3_in_valid = 3'b111;
        @(negedge clk);
        checks++;
        if (s3_in_ready !== 3'b000 || s3_sel_err !== 1'b0) begin
            errors++;
            $display("FAIL sel_err_first got rdy=%b err=%b expected rdy=000 err=0", s3_in_ready, s3_sel_err);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (s3_in_ready !== 3'b000 || s3_sel_err !== 1'b1) begin
            errors++;
            $display("FAIL sel_err_pulse got rdy=%b err=%b expected rdy=000 err=1", s3_in_ready, s3_sel_err);
        end
        @(posedge clk); #1;
        s3_in_valid = 3'b000;
        @(negedge clk);
        checks++;
        if (s3_sel_err !== 1'b1) begin
            errors++;
            $display("FAIL sel_err_last got err=%b expected 1", s3_sel_err);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (s3_sel_err !== 1'b0) begin
            errors++;
            $display("FAIL sel_err_idle got err=%b expected 0 (sel out of range, nothing valid)", s3_sel_err);
        end
        // Highest legal channel of a non-power-of-two mux still transfers.
        @(posedge clk); #1;
        s3_sel = 2'd2;
        s3_in_valid = 3'b100;
        @(negedge clk);
        checks++;
        if (s3_in_ready !== 3'b100) begin
            errors++;
            $display("FAIL sel3_top_ready got %b expected 100", s3_in_ready);
        end
        q_s3.push_back({2'd2, 32'hC0DE0002});
        @(posedge clk); #1;
        s3_in_valid = 3'b000;
        for (int i = 0; i < 20 && q_s3.size() != 0; i++) @(negedge clk);
        checks++;
        if (q_s3.size() != 0 || s3_sel_err !== 1'b0) begin
            errors++;
            $display("FAIL sel3_drain got pending=%0d err=%b expected 0/0", q_s3.size(), s3_sel_err);
        end
    endtask

    task automatic test_rr_rotate();
        rr_out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) rr_in_data[i*32 +: 32] = 32'h5A000000 + 32'(c*16 + i);
            rr_in_valid = 4'hF;
            @(negedge clk);
            checks++;
            if (rr_in_ready !== (4'b0001 << (c % 4))) begin
                errors++;
                $display("FAIL rr_rotate_ready cycle=%0d got %b expected %b", c, rr_in_ready, 4'b0001 << (c % 4));
            end
            if (c > 0) begin
                checks++;
                if (rr_out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_throughput cycle=%0d got out_valid=%b expected 1", c, rr_out_valid);
                end
            end
            q_rr.push_back({2'(c % 4), 32'h5A000000 + 32'(c*16 + c % 4)});
        end
        rr_ptr_m = 2'd3;
        @(posedge clk); #1;
        rr_in_valid = '0;
        for (int i = 0; i < 20 && q_rr.size() != 0; i++) @(negedge clk);
        checks++;
        if (q_rr.size() != 0) begin
            errors++;
            $display("FAIL rr_rotate_drain got %0d pending expected 0", q_rr.size());
        end
    endtask

    task automatic test_backpressure();
        rr_out_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            rr_in_data = '0;
            rr_in_data[31:0] = (c <= 2) ? 32'(c) : 32'd3;
            rr_in_valid = 4'b0001;
            @(negedge clk);
            checks++;
            if (rr_in_ready !== ((c <= 2) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL bp_ready cycle=%0d got %b expected %b", c, rr_in_ready,
                         (c <= 2) ? 4'b0001 : 4'b0000);
            end
            if (c <= 2) q_rr.push_back({2'd0, 32'(c)});
            if (c >= 3) begin
                checks++;
                if (rr_out_valid !== 1'b1 || rr_out_data !== 32'd1 || rr_out_idx !== 2'd0) begin
                    errors++;
                    $display("FAIL bp_hold cycle=%0d got valid=%b data=%h idx=%0d expected 1/1/0",
                             c, rr_out_valid, rr_out_data, rr_out_idx);
                end
            end
        end
        // First drain frees the skid; word 3 is taken the cycle after.
        @(posedge clk); #1;
        rr_out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rr_in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_release_ready got %b expected 0000", rr_in_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rr_in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_resume_ready got %b expected 0001", rr_in_ready);
        end
        q_rr.push_back({2'd0, 32'd3});
        rr_ptr_m = 2'd0;
        @(posedge clk); #1;
        rr_in_valid = '0;
        for (int i = 0; i < 20 && q_rr.size() != 0; i++) @(negedge clk);
        checks++;
        if (q_rr.size() != 0) begin
            errors++;
            $display("FAIL bp_drain got %0d pending expected 0", q_rr.size());
        end
    endtask

    task automatic test_rr_sparse();
        logic [3:0] pats [8] = '{4'b0010, 4'b1010, 4'b0000, 4'b0000,
                                 4'b0000, 4'b1010, 4'b1010, 4'b1010};
        logic [2:0] pick;
        logic [3:0] exp_rdy;
        rr_out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) rr_in_data[i*32 +: 32] = 32'h3C000000 + 32'(c*16 + i);
            rr_in_valid = pats[c];
            pick = rr_pick(rr_ptr_m, pats[c]);
            exp_rdy = pick[2] ? (4'b0001 << pick[1:0]) : 4'b0000;
            @(negedge clk);
            checks++;
            if (rr_in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_sparse_ready cycle=%0d valid=%b got %b expected %b",
                         c, pats[c], rr_in_ready, exp_rdy);
            end
            if (pick[2]) begin
                q_rr.push_back({pick[1:0], 32'h3C000000 + 32'(c*16) + 32'(pick[1:0])});
                rr_ptr_m = pick[1:0];
            end
        end
        @(posedge clk); #1;
        rr_in_valid = '0;
        for (int i = 0; i < 20 && q_rr.size() != 0; i++) @(negedge clk);
        checks++;
        if (q_rr.size() != 0) begin
            errors++;
            $display("FAIL rr_sparse_drain got %0d pending expected 0", q_rr.size());
        end
    endtask

    task automatic test_reset_mid();
        rr_out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            rr_in_data = '0;
            rr_in_data[2*32 +: 32] = 32'h77770001 + 32'(c);
            rr_in_valid = 4'b0100;
        end
        @(posedge clk); #1;
        rr_in_valid = '0;
        @(negedge clk);
        checks++;
        if (rr_out_valid !== 1'b1 || rr_in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_buffered got valid=%b rdy=%b expected 1/0000", rr_out_valid, rr_in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        rr_in_valid = 4'hF;
        @(negedge clk);
        checks++;
        if (rr_in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_rst_ready got %b expected 0000 while reset is high", rr_in_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rr_out_valid !== 1'b0 || rr_out_data !== 32'd0 || rr_out_idx !== 2'd0) begin
            errors++;
            $display("FAIL mid_rst_out got valid=%b data=%h idx=%0d expected 0/0/0",
                     rr_out_valid, rr_out_data, rr_out_idx);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        rr_ptr_m = 2'd3;
        rr_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) rr_in_data[i*32 +: 32] = 32'h99990000 + 32'(i);
        rr_in_valid = 4'hF;
        @(negedge clk);
        checks++;
        if (rr_in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_first_grant got %b expected 0001", rr_in_ready);
        end
        q_rr.push_back({2'd0, 32'h99990000});
        @(posedge clk); #1;
        rr_in_valid = '0;
        for (int i = 0; i < 20 && q_rr.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (q_rr.size() != 0) begin
            errors++;
            $display("FAIL mid_drain got %0d pending expected 0", q_rr.size());
        end
    endtask

    initial begin
        test_reset();
        test_sel_basic();
        test_sel_err();
        test_rr_rotate();
        test_backpressure();
        test_rr_sparse();
        test_reset_mid();
        checks++;
        if (rr_sel_err !== 1'b0) begin
            errors++;
            $display("FAIL rr_sel_err got %b expected 0", rr_sel_err);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
